aoi_reduce_pipe: RTL and testbench
==================================

// Module: aoi_reduce_pipe
// PURPOSE
// - Parametrised, pipelined successor to the fixed 3x2 AND-OR-INVERT cells.
// - Computes a WIDTH-bit-lane reduction over NUM_GROUPS groups of GROUP_SIZE operands each.
// - Runtime mode selects AOI, AO, OAI or OA.
// - valid/ready handshake on both sides; output toggle counter for activity/power characterisation.
// - Sits between datapath producers and the characterisation/compare logic.
// PARAMETERS
// - WIDTH       default 8   bits per operand (bitwise lanes)
// - GROUP_SIZE  default 2   operands per group (AOI222 = 2)
// - NUM_GROUPS  default 3   groups (AOI222 = 3)
// - CNT_W       default 16  toggle counter width (saturating)
// PORTS
// - CK          in   1                              clock, rising edge
// - RN          in   1                              synchronous active-low reset
// - in_valid    in   1                              operand set valid
// - in_ready    out  1                              block accepts operand set
// - in_mode     in   2                              00 AOI, 01 AO, 10 OAI, 11 OA; sampled with data
// - in_data     in   WIDTH*GROUP_SIZE*NUM_GROUPS    operand g*GROUP_SIZE+k at [(g*GROUP_SIZE+k)*WIDTH +: WIDTH]
// - out_valid   out  1                              result valid
// - out_ready   in   1                              consumer accepts result
// - out_zn      out  WIDTH                          result
// - cnt_clr     in   1                              synchronous clear of toggle_cnt
// - toggle_cnt  out  CNT_W                          accumulated output bit toggles
// BEHAVIOUR
// - Reset: RN sampled low at a CK edge clears all stage valids, out_zn, the last-delivered reference and toggle_cnt to 0.
//   - in_ready is forced 0 while RN=0.
//   - Reset mid-transfer drops in-flight data silently; no output follows.
// - Stage 1 (registered): per group, per lane:
//   - AND of the GROUP_SIZE operands for modes AOI and AO.
//   - OR of the GROUP_SIZE operands for modes OAI and OA.
//   - Mode travels with the data.
// - Stage 2 (registered):
//   - Combines group results with OR (AOI/AO) or AND (OAI/OA).
//   - Inverts for AOI/OAI.
//   - Drives out_zn.
// - Latency: exactly 2 cycles from in_valid&&in_ready to out_valid with no backpressure.
// - Throughput: 1 result per cycle.
// - Handshake:
//   - A transfer occurs when valid&&ready at a CK edge.
//   - out_valid and out_zn are held stable until out_ready.
//   - out_valid never deasserts without a transfer, except on reset.
//   - in_ready = !s1_valid || s1 advances this cycle. This is a combinational path from out_ready through both stages; full-throughput backpressure is required.
//   - in_mode and in_data are don't-care when in_valid=0.
// - Ordering: results leave in acceptance order; no drops, no duplicates.
// - Toggle counter:
//   - On each output transfer, add popcount(out_zn ^ last_delivered) to toggle_cnt, then last_delivered <= out_zn.
//   - The first transfer after reset compares against 0.
//   - Saturates at 2^CNT_W-1; no wrap.
//   - cnt_clr and a transfer in the same cycle: the counter loads the current transfer's popcount (clear, then add). last_delivered still updates.
//   - cnt_clr does not touch last_delivered.
// - Elaboration error if WIDTH<1, GROUP_SIZE<1, NUM_GROUPS<1, or CNT_W < $clog2(WIDTH+1).
// STRUCTURE
// - Package aoi_pkg:
//   - aoi_mode_e enum: AOI=2'b00, AO=2'b01, OAI=2'b10, OA=2'b11.
//   - Helper function mode_inverts(aoi_mode_e).
//   - Helper function mode_inner_and(aoi_mode_e).
// - Sub-module aoi_pipe_stage:
//   - Parametrised-width valid/ready register slice.
//   - Instantiated twice: stage 1 payload = mode + NUM_GROUPS*WIDTH; stage 2 payload = WIDTH.
// - Popcount and toggle accumulator stay in the top module.
// TESTING
// - Defaults, mode AOI, operands {A1,A2,B1,B2,C1,C2} lane 0 = {1,1,0,0,0,0}: out_zn[0]=0 two cycles after accept. All-zero operands: out_zn=8'hFF.
// - Exhaustive 64 lane-0 patterns x 4 modes, out_ready=1: every result matches the reference model; accept-to-valid latency is 2; one result per cycle.
// - Back-to-back stream, out_ready held 0 for 5 cycles:
//   - in_ready drops after 2 accepts.
//   - out_zn stays stable during the stall.
//   - All results are delivered in order after release.
// - Alternating outputs 8'h00 / 8'hFF over 10 transfers: toggle_cnt=80. With CNT_W=6: toggle_cnt saturates at 63.
// - cnt_clr asserted coincident with a transfer whose XOR popcount is 3: toggle_cnt=3 next cycle.
// - RN pulled low with 2 results in flight:
//   - Next cycle out_valid=0, toggle_cnt=0, in_ready=0.
//   - After release, the first result compares against 0.

Source files
------------

// File: rtl/aoi_pkg.sv
// Shared mode encoding and mode-decode helpers for the AND-OR-INVERT reduction pipeline.
package aoi_pkg;

  typedef enum logic [1:0] {
    AOI = 2'b00,
    AO  = 2'b01,
    OAI = 2'b10,
    OA  = 2'b11
  } aoi_mode_e;

  localparam int MODE_W = 2;

  function automatic logic mode_inverts(aoi_mode_e m);
    return (m == AOI) || (m == OAI);
  endfunction

  // Inner (per-group) operator is AND for AOI/AO; the outer combine is then OR.
  function automatic logic mode_inner_and(aoi_mode_e m);
    return (m == AOI) || (m == AO);
  endfunction

endpackage

// File: rtl/aoi_pipe_stage.sv
// Single valid/ready register slice: one cycle latency, full throughput.
// Ready passes combinationally from downstream so a full slice can refill while it drains.
module aoi_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = rst_ni && (!vld_q || out_rdy_i);
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_rdy_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) dat_d = in_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/aoi_reduce_pipe.sv
// Two-stage pipelined AOI/AO/OAI/OA reduction with valid/ready on both sides.
// Latency 2 cycles, 1 result/cycle; out_ready ripples combinationally back to in_ready.
module aoi_reduce_pipe
  import aoi_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GROUP_SIZE = 2,
  parameter int NUM_GROUPS = 3,
  parameter int CNT_W      = 16
) (
  input  logic                                 CK,
  input  logic                                 RN,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [1:0]                           in_mode,
  input  logic [WIDTH*GROUP_SIZE*NUM_GROUPS-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     out_zn,
  input  logic                                 cnt_clr,
  output logic [CNT_W-1:0]                     toggle_cnt
);

  localparam int GRP_W = NUM_GROUPS * WIDTH;
  localparam int S1_W  = MODE_W + GRP_W;
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + 1;

  if (WIDTH < 1 || GROUP_SIZE < 1 || NUM_GROUPS < 1 || CNT_W < $clog2(WIDTH + 1)) begin : g_param_err
    $error("aoi_reduce_pipe: illegal parameter combination");
  end

  aoi_mode_e        in_mode_e, s1_mode;
  logic [GRP_W-1:0] grp_d, s1_grp;
  logic [WIDTH-1:0] acc, op, res_d;
  logic [S1_W-1:0]  s1_dat;
  logic             s1_vld, s2_rdy;

  assign in_mode_e = aoi_mode_e'(in_mode);

  always_comb begin
    grp_d = '0;
    acc   = '0;
    op    = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      acc = mode_inner_and(in_mode_e) ? '1 : '0;
      for (int k = 0; k < GROUP_SIZE; k++) begin
        op  = in_data[(g*GROUP_SIZE+k)*WIDTH +: WIDTH];
        acc = mode_inner_and(in_mode_e) ? (acc & op) : (acc | op);
      end
      grp_d[g*WIDTH +: WIDTH] = acc;
    end
  end

  aoi_pipe_stage #(.W(S1_W)) u_s1 (
    .clk_i     (CK),
    .rst_ni    (RN),
    .in_vld_i  (in_valid),
    .in_rdy_o  (in_ready),
    .in_dat_i  ({in_mode, grp_d}),
    .out_vld_o (s1_vld),
    .out_rdy_i (s2_rdy),
    .out_dat_o (s1_dat)
  );

  assign s1_mode = aoi_mode_e'(s1_dat[S1_W-1 -: MODE_W]);
  assign s1_grp  = s1_dat[GRP_W-1:0];

  // Outer combine is the dual of the inner operator.
  always_comb begin
    res_d = mode_inner_and(s1_mode) ? '0 : '1;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      res_d = mode_inner_and(s1_mode) ? (res_d | s1_grp[g*WIDTH +: WIDTH])
                                      : (res_d & s1_grp[g*WIDTH +: WIDTH]);
    end
    if (mode_inverts(s1_mode)) res_d = ~res_d;
  end

  aoi_pipe_stage #(.W(WIDTH)) u_s2 (
    .clk_i     (CK),
    .rst_ni    (RN),
    .in_vld_i  (s1_vld),
    .in_rdy_o  (s2_rdy),
    .in_dat_i  (res_d),
    .out_vld_o (out_valid),
    .out_rdy_i (out_ready),
    .out_dat_o (out_zn)
  );

  logic [WIDTH-1:0] last_q, last_d, diff;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] cnt_sum;
  logic             out_xfer;

  assign out_xfer   = out_valid && out_ready;
  assign diff       = out_zn ^ last_q;
  assign toggle_cnt = cnt_q;

  // Clear takes effect before the add so a coincident transfer is still counted.
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PC_W'(diff[i]);
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + SUM_W'(pc);
    cnt_d    = cnt_base;
    last_d   = last_q;
    if (out_xfer) begin
      cnt_d  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      last_d = out_zn;
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_aoi_reduce_pipe.sv
// Directed bench for aoi_reduce_pipe: vector table, exhaustive lane-0 sweep, stall, toggle and reset cases.
module tb_aoi_reduce_pipe;

  logic        clk = 1'b0;
  logic        rn;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic [47:0] in_data;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid;
  logic [7:0]  out_zn;
  logic [15:0] toggle_cnt;
  logic        in_ready_s, out_valid_s;
  logic [7:0]  out_zn_s;
  logic [5:0]  toggle_cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aoi_reduce_pipe u_dut (
    .CK(clk), .RN(rn), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_zn(out_zn),
    .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt)
  );

  aoi_reduce_pipe #(.CNT_W(6)) u_sat (
    .CK(clk), .RN(rn), .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_zn(out_zn_s),
    .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt_s)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [47:0] data;
    logic [7:0]  exp;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Operands packed {C2,C1,B2,B1,A2,A1}, A1 in the low byte.
  function automatic logic [7:0] model(input logic [1:0] m, input logic [47:0] d);
    logic [7:0] a1, a2, b1, b2, c1, c2, ao, oa;
    {c2, c1, b2, b1, a2, a1} = d;
    ao = (a1 & a2) | (b1 & b2) | (c1 & c2);
    oa = (a1 | a2) & (b1 | b2) & (c1 | c2);
    case (m)
      2'b00:   return ~ao;
      2'b01:   return ao;
      2'b10:   return ~oa;
      default: return oa;
    endcase
  endfunction

  task automatic send_one(input logic [1:0] m, input logic [47:0] d,
                          output logic [7:0] zn, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    #1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    zn = out_zn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rn = 1'b0;
    @(negedge clk);
    rn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  zn;
    logic [47:0] d;
    logic [5:0]  p;
    logic [6:0]  r;
    logic [7:0]  exp_q[$];
    int          acc_q[$];
    int          lat, cyc, k, accepts, delivered;
    int          sel[6];

    tv[0] = '{2'b00, 48'h0000_0000_0101, 8'hFE};
    tv[1] = '{2'b00, 48'h0000_0000_0000, 8'hFF};
    tv[2] = '{2'b01, 48'h0000_0000_0000, 8'h00};
    tv[3] = '{2'b10, 48'h0000_0000_0000, 8'hFF};
    tv[4] = '{2'b11, 48'hFFFF_FFFF_FFFF, 8'hFF};
    tv[5] = '{2'b00, 48'h80C0_0F0F_3CF0, 8'h40};
    tv[6] = '{2'b11, 48'h00FF_0201_0FF0, 8'h03};
    tv[7] = '{2'b10, 48'h00FF_0201_0FF0, 8'hFC};
    tv[8] = '{2'b01, 48'h0000_5055_FFAA, 8'hFA};
    sel   = '{0, 2, 5, 6, 7, 8};

    rn = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_zn", out_zn, 0);
    chk("rst_toggle", toggle_cnt, 0);
    chk("rst_toggle_sat", toggle_cnt_s, 0);
    chk("rst_in_ready", in_ready, 0);
    rn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send_one(tv[i].mode, tv[i].data, zn, lat);
      chk($sformatf("vec%0d_zn", i), zn, tv[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 2);
    end
    @(negedge clk);

    // Exhaustive lane-0 sweep, streamed back to back with random upper lanes.
    k = 0; cyc = 0; delivered = 0;
    while ((k < 256 || exp_q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (k < 256) begin
        p = 6'(k >> 2);
        for (int j = 0; j < 6; j++) begin
          r = 7'($urandom());
          d[j*8 +: 8] = {r, p[j]};
        end
        in_valid = 1'b1; in_mode = 2'(k); in_data = d;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ex_spurious: out_valid with nothing outstanding at cycle %0d", cyc);
        end else begin
          chk("ex_zn", out_zn, exp_q.pop_front());
          chk("ex_lat", cyc - acc_q.pop_front(), 2);
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_mode, in_data));
        acc_q.push_back(cyc);
        k++;
      end
      cyc++;
    end
    chk("ex_delivered", delivered, 256);
    chk("ex_cycles", cyc, 258);

    // Back-to-back stream with the consumer stalled for 5 cycles.
    exp_q.delete();
    k = 0; accepts = 0; delivered = 0;
    for (cyc = 0; cyc < 40 && delivered < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (k < 6) begin
        in_valid = 1'b1; in_mode = tv[sel[k]].mode; in_data = tv[sel[k]].data;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) chk("stall_in_ready", in_ready, 0);
      if (cyc == 4) chk("stall_accepts", accepts, 2);
      if (out_valid && exp_q.size() > 0) begin
        if (!out_ready) chk("stall_hold", out_zn, exp_q[0]);
        else begin
          chk("stall_order", out_zn, exp_q.pop_front());
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(tv[sel[k]].exp);
        k++; accepts++;
      end
    end
    chk("stall_delivered", delivered, 6);
    @(negedge clk);
    in_valid = 1'b0;

    // Alternating FF/00 outputs; first transfer toggles all 8 bits against the reset reference.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b01;
      in_data = (i % 2 == 0) ? 48'h0000_0000_FFFF : 48'h0;
      #1;
      chk("tog_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("tog_cnt", toggle_cnt, 80);
    chk("tog_cnt_sat", toggle_cnt_s, 63);

    // Clear coincident with a transfer of 8'h07 against reference 8'h00.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b01; in_data = 48'h0000_0000_0707;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("clr_out_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr_cnt", toggle_cnt, 3);
    chk("clr_cnt_sat", toggle_cnt_s, 3);

    // Reset with two results in flight, consumer stalled.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_data = tv[5].data;
    @(negedge clk);
    in_data = tv[6].data; in_mode = tv[6].mode;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("flight_s2_full", out_valid, 1);
    rn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_toggle", toggle_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rn = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_no_stale", out_valid, 0);
    send_one(2'b01, 48'h0000_0000_0F0F, zn, lat);
    chk("post_rst_zn", zn, 8'h0F);
    chk("post_rst_lat", lat, 2);
    @(negedge clk);
    #1;
    chk("post_rst_toggle", toggle_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
